bcd_adder_seq: RTL and testbench

- Multi-digit, parametrised BCD adder for the switch/LED/seven-segment lab designs.
- Captures two DIGITS-wide BCD operands on a start pulse and adds them serially, one digit per clock, least-significant digit first, with decimal-adjust.
- Flags any non-BCD input digit and drives registered result digits onto active-low seven-segment outputs.

---
 rtl/bcd_pkg.sv | 53 +++++
 rtl/bcd_seg_decoder.sv | 11 +
 rtl/bcd_adder_seq.sv | 161 ++++++++++++++++
 tb/tb_bcd_adder_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types, constants and per-digit arithmetic for the serial BCD adder.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StDone
  } state_e;

  // Active-low patterns, index = digit value; non-decimal codes are blanked.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, SEG_BLANK,  SEG_BLANK,
    SEG_BLANK,  SEG_BLANK,  SEG_BLANK,  SEG_BLANK
  };

  typedef struct packed {
    logic               carry;
    logic [DIGIT_W-1:0] digit;
  } digit_sum_t;

  function automatic digit_sum_t bcd_digit_add(input logic [DIGIT_W-1:0] x,
                                               input logic [DIGIT_W-1:0] y,
                                               input logic               c);
    logic [DIGIT_W:0] t;
    digit_sum_t       r;
    t = {1'b0, x} + {1'b0, y} + {{DIGIT_W{1'b0}}, c};
    if (t > 5'd9) begin
      r.digit = DIGIT_W'(t + 5'd6);
      r.carry = 1'b1;
    end else begin
      r.digit = t[DIGIT_W-1:0];
      r.carry = 1'b0;
    end
    return r;
  endfunction

  // Wraps mod 16 so invalid digits still produce a defined value.
  function automatic logic [DIGIT_W-1:0] nines_comp(input logic [DIGIT_W-1:0] d);
    return 4'd9 - d;
  endfunction

  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder.
module bcd_seg_decoder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [SEG_W-1:0]   seg_o
);

  assign seg_o = SEG_TABLE[digit_i];

endmodule

// File: rtl/bcd_adder_seq.sv
// Serial multi-digit BCD adder, one digit per clock, LSD first, with 7-seg output.
// Optional BCD_SUB_EN adds a sub input for tens-complement subtraction.
module bcd_adder_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DIGIT_W*DIGITS-1:0]   a,
  input  logic [DIGIT_W*DIGITS-1:0]   b,
  input  logic                        cin,
`ifdef BCD_SUB_EN
  input  logic                        sub,
`endif
  output logic                        busy,
  output logic                        done,
  output logic [DIGIT_W*DIGITS-1:0]   sum,
  output logic                        cout,
  output logic                        err,
  output logic [SEG_W*(DIGITS+1)-1:0] seg
);

  localparam int unsigned W    = DIGIT_W * DIGITS;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    work_q, work_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [W-1:0]    b_eff;
  logic            cin_eff;
  logic            in_err;
  digit_sum_t      dsum;
  logic [W+DIGIT_W-1:0] work_shift;

  // Operand B as it enters the datapath; subtraction folds into the same adder.
  always_comb begin
    b_eff   = b;
    cin_eff = cin;
`ifdef BCD_SUB_EN
    if (sub) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        b_eff[i*DIGIT_W +: DIGIT_W] = nines_comp(b[i*DIGIT_W +: DIGIT_W]);
      end
      cin_eff = 1'b1;
    end
`endif
  end

  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      in_err = in_err | digit_invalid(a[i*DIGIT_W +: DIGIT_W])
                      | digit_invalid(b[i*DIGIT_W +: DIGIT_W]);
    end
  end

  // Operands shift right each cycle so the current digit is always at the bottom.
  assign dsum       = bcd_digit_add(a_q[DIGIT_W-1:0], b_q[DIGIT_W-1:0], carry_q);
  assign work_shift = {dsum.digit, work_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b_eff;
          carry_d = cin_eff;
          err_d   = in_err;
          idx_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        a_d     = a_q >> DIGIT_W;
        b_d     = b_q >> DIGIT_W;
        carry_d = dsum.carry;
        work_d  = work_shift[W+DIGIT_W-1:DIGIT_W];
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        sum_d   = work_q;
        cout_d  = carry_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

  for (genvar g = 0; g <= int'(DIGITS); g++) begin : g_seg
    logic [DIGIT_W-1:0] digit;
    if (g < int'(DIGITS)) begin : g_sum
      assign digit = sum_q[g*DIGIT_W +: DIGIT_W];
    end else begin : g_cout
      assign digit = {{(DIGIT_W-1){1'b0}}, cout_q};
    end
    bcd_seg_decoder u_dec (
      .digit_i (digit),
      .seg_o   (seg[g*SEG_W +: SEG_W])
    );
  end

endmodule

// File: tb/tb_bcd_adder_seq.sv
// Directed bench for bcd_adder_seq with DIGITS=3; sub-mode vectors run under BCD_SUB_EN.
module tb_bcd_adder_seq;

  localparam int D = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [11:0]   a = '0;
  logic [11:0]   b = '0;
  logic          cin = 1'b0;
`ifdef BCD_SUB_EN
  logic          sub = 1'b0;
`endif
  logic          busy, done, cout, err;
  logic [11:0]   sum;
  logic [27:0]   seg;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_adder_seq #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef BCD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err),
    .seg   (seg)
  );

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic        cin;
    logic        sub;
    logic [11:0] sum;
    logic        cout;
    logic        err;
  } vec_t;

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] exp_seg(input logic [11:0] s, input logic c);
    return {seg_pat({3'b000, c}), seg_pat(s[11:8]), seg_pat(s[7:4]), seg_pat(s[3:0])};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns at the negedge just after the capturing edge.
  task automatic start_op(input logic [11:0] av, input logic [11:0] bv, input logic cv,
                          input logic sv);
    @(negedge clk);
    a = av;
    b = bv;
    cin = cv;
`ifdef BCD_SUB_EN
    sub = sv;
`else
    if (sv) $display("note: sub vector skipped in add-only build");
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    start_op(v.a, v.b, v.cin, v.sub);
    check({name, " err@capture"}, 32'(err), 32'(v.err));
    wait_done(lat);
    check({name, " latency"}, 32'(lat), 32'(D + 1));
    check({name, " sum"}, 32'(sum), 32'(v.sum));
    check({name, " cout"}, 32'(cout), 32'(v.cout));
    check({name, " err"}, 32'(err), 32'(v.err));
    check({name, " seg"}, 32'(seg), 32'(exp_seg(v.sum, v.cout)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   lat;
    int   ndone;

    vecs.push_back('{12'h456, 12'h789, 1'b0, 1'b0, 12'h245, 1'b1, 1'b0});
    vecs.push_back('{12'h999, 12'h000, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0});
    vecs.push_back('{12'h0A5, 12'h001, 1'b0, 1'b0, 12'h106, 1'b0, 1'b1});
    vecs.push_back('{12'h123, 12'h456, 1'b1, 1'b0, 12'h580, 1'b0, 1'b0});
    vecs.push_back('{12'h001, 12'h998, 1'b0, 1'b0, 12'h999, 1'b0, 1'b0});
    vecs.push_back('{12'h500, 12'h500, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0});
    vecs.push_back('{12'h0F0, 12'h0F0, 1'b0, 1'b0, 12'h140, 1'b0, 1'b1});
    vecs.push_back('{12'h358, 12'h642, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0});
    vecs.push_back('{12'h000, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0});
`ifdef BCD_SUB_EN
    vecs.push_back('{12'h500, 12'h123, 1'b0, 1'b1, 12'h377, 1'b1, 1'b0});
    vecs.push_back('{12'h123, 12'h500, 1'b0, 1'b1, 12'h623, 1'b0, 1'b0});
    vecs.push_back('{12'h456, 12'h789, 1'b0, 1'b0, 12'h245, 1'b1, 1'b0});
`endif

    // Power-up reset
    #2 rst = 1'b1;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset sum", 32'(sum), 32'h000);
    check("reset cout", 32'(cout), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset seg", 32'(seg), 32'(exp_seg(12'h000, 1'b0)));
    @(negedge clk);
    rst = 1'b0;

    // Cycle-accurate handshake on the basic add
    start_op(12'h456, 12'h789, 1'b0, 1'b0);
    for (int n = 0; n <= D + 1; n++) begin
      check($sformatf("basic busy c%0d", n), 32'(busy), 32'(n <= D));
      check($sformatf("basic done c%0d", n), 32'(done), 32'(n == D + 1));
      if (n <= D) @(negedge clk);
    end
    check("basic sum", 32'(sum), 32'h245);
    check("basic cout", 32'(cout), 32'd1);
    check("basic seg0", 32'(seg[6:0]), 32'(7'b0010010));
    @(negedge clk);
    check("basic done pulse", 32'(done), 32'd0);
    check("basic sum held", 32'(sum), 32'h245);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Start held high during ADD and over the DONE->IDLE edge is ignored
    start_op(12'h456, 12'h789, 1'b0, 1'b0);
    @(negedge clk);
    a = 12'h111;
    b = 12'h111;
    start = 1'b1;
    ndone = 0;
    for (int n = 2; n <= D + 1; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    start = 1'b0;
    check("hs done count", 32'(ndone), 32'd1);
    check("hs sum", 32'(sum), 32'h245);
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("hs not queued", 32'(ndone), 32'd0);
    check("hs idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-operation
    start_op(12'h0A5, 12'h001, 1'b0, 1'b0);
    @(negedge clk);
    check("abort err set", 32'(err), 32'd1);
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort sum", 32'(sum), 32'h000);
    check("abort cout", 32'(cout), 32'd0);
    check("abort err", 32'(err), 32'd0);
    check("abort seg", 32'(seg), 32'(exp_seg(12'h000, 1'b0)));
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no done", 32'(ndone), 32'd0);
    start_op(12'h123, 12'h456, 1'b1, 1'b0);
    wait_done(lat);
    check("post-abort latency", 32'(lat), 32'(D + 1));
    check("post-abort sum", 32'(sum), 32'h580);
    check("post-abort cout", 32'(cout), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
